// File: rtl/baccarat_pkg.sv
// Shared Baccarat definitions: rank limits, round state and modulo-10 point arithmetic.
package baccarat_pkg;

    localparam logic [3:0] ACE       = 4'd1;
    localparam logic [3:0] KING      = 4'd13;
    localparam logic [3:0] POINT_MOD = 4'd10;

    typedef enum logic {
        COLLECT  = 1'b0,
        RESOLVED = 1'b1
    } state_t;

    // Both operands are below POINT_MOD, so one conditional subtraction is exact.
    function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 5'(POINT_MOD)) begin
            sum = sum - 5'(POINT_MOD);
        end
        return sum[3:0];
    endfunction

endpackage

// File: rtl/multi_hand_scorer_if.sv
// Card offer handshake between the dealer (master) and the scorer (slave).
interface multi_hand_scorer_if #(
    parameter int HAND_W = 1
);
    logic              card_valid;
    logic              card_ready;
    logic [HAND_W-1:0] card_hand;
    logic [3:0]        card;

    modport master (output card_valid, card_hand, card, input card_ready);
    modport slave  (input card_valid, card_hand, card, output card_ready);
endinterface

// File: rtl/card_to_points.sv
// Maps a card rank to its Baccarat point value and flags ranks outside Ace..King.
module card_to_points
    import baccarat_pkg::*;
(
    input  logic [3:0] rank,
    output logic [3:0] points,
    output logic       legal
);

    // NOTE: every output gets a default before any condition so no latch is inferred.
    always_comb begin
        points = 4'd0;
        legal  = (rank >= ACE) && (rank <= KING);
        if (legal && (rank < POINT_MOD)) begin
            points = rank;
        end
    end

endmodule

// File: rtl/multi_hand_scorer.sv
// Multi-hand Baccarat scorer: routes one card per cycle to a hand, keeps running
// modulo-10 scores, and registers the winner/tie outcome on a resolve request.
module multi_hand_scorer
    import baccarat_pkg::*;
#(
    parameter int N_HANDS   = 2,
    parameter int MAX_CARDS = 3,
    parameter int HAND_W    = (N_HANDS > 1) ? $clog2(N_HANDS) : 1,
    parameter int CNT_W     = $clog2(MAX_CARDS + 1)
) (
    input  logic                     slow_clock,
    input  logic                     resetb,
    input  logic                     clear,
    input  logic                     resolve,
    multi_hand_scorer_if.slave       card_bus,
    output logic [4*N_HANDS-1:0]     score,
    output logic [CNT_W*N_HANDS-1:0] count,
    output logic [N_HANDS-1:0]       natural,
    output logic                     err,
    output logic                     done,
    output logic [HAND_W-1:0]        winner,
    output logic                     tie
);

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        points;
    logic              legal;
    logic              accept;
    logic              hand_ok;
    logic              hand_full;
    logic              bad;
    logic              good;
    logic              do_resolve;
    logic [3:0]        score_q [N_HANDS];
    logic [CNT_W-1:0]  count_q [N_HANDS];
    logic [3:0]        max_score;
    logic [HAND_W-1:0] max_idx;
    logic              max_tie;
    logic              max_seen;

    card_to_points u_points (
        .rank   (card_bus.card),
        .points (points),
        .legal  (legal)
    );

    assign card_bus.card_ready = (state_q == COLLECT) && !clear && !resolve;
    assign accept     = card_bus.card_valid && card_bus.card_ready;
    assign hand_ok    = 32'(card_bus.card_hand) < 32'(N_HANDS);
    assign bad        = accept && (!legal || !hand_ok || hand_full);
    assign good       = accept && !bad;
    assign do_resolve = resolve && !clear && (state_q == COLLECT);

    always_comb begin
        hand_full = 1'b0;
        for (int h = 0; h < N_HANDS; h++) begin
            if ((32'(card_bus.card_hand) == 32'(h)) && (count_q[h] == CNT_W'(MAX_CARDS))) begin
                hand_full = 1'b1;
            end
        end
    end

    // Lowest index wins among equal maxima; a second holder of the maximum marks a tie.
    always_comb begin
        max_score = 4'd0;
        max_idx   = '0;
        max_tie   = 1'b0;
        max_seen  = 1'b0;
        for (int h = 0; h < N_HANDS; h++) begin
            if (score_q[h] > max_score) begin
                max_score = score_q[h];
                max_idx   = HAND_W'(h);
            end
        end
        for (int h = 0; h < N_HANDS; h++) begin
            if (score_q[h] == max_score) begin
                max_tie  = max_tie | max_seen;
                max_seen = 1'b1;
            end
        end
    end

    for (genvar h = 0; h < N_HANDS; h++) begin : g_hand
        logic             hit;
        logic [3:0]       s_q;
        logic [CNT_W-1:0] c_q;
        logic             nat_q;
        logic [3:0]       s_nxt;
        logic [CNT_W-1:0] c_nxt;

        assign hit   = good && (32'(card_bus.card_hand) == 32'(h));
        assign s_nxt = add_mod10(s_q, points);
        assign c_nxt = c_q + 1'b1;

        always_ff @(posedge slow_clock) begin
            if (!resetb || clear) begin
                s_q   <= 4'd0;
                c_q   <= '0;
                nat_q <= 1'b0;
            end else if (hit) begin
                s_q   <= s_nxt;
                c_q   <= c_nxt;
                nat_q <= (c_nxt == CNT_W'(2)) && (s_nxt >= 4'd8);
            end
        end

        assign score_q[h]              = s_q;
        assign count_q[h]              = c_q;
        assign score[4*h +: 4]         = s_q;
        assign count[CNT_W*h +: CNT_W] = c_q;
        assign natural[h]              = nat_q;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = COLLECT;
        end else if (do_resolve) begin
            state_d = RESOLVED;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb || clear) begin
            err    <= 1'b0;
            done   <= 1'b0;
            winner <= '0;
            tie    <= 1'b0;
        end else begin
            err <= bad;
            if (do_resolve) begin
                done   <= 1'b1;
                winner <= max_idx;
                tie    <= max_tie;
            end
        end
    end

endmodule
